// File: rtl/expr_arbiter_pkg.sv
// Shared encodings and byte constants for the two-requester expression arbiter.
// Holds the top FSM states, checker states and ASCII class helpers.
package expr_arbiter_pkg;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_RUN    = 2'd1,
        S_REPORT = 2'd2
    } fsm_t;

    typedef enum logic [1:0] {
        C_INIT = 2'd0,
        C_NUM  = 2'd1,
        C_OP   = 2'd2,
        C_ERR  = 2'd3
    } chk_t;

    localparam logic [7:0] CH_ZERO = 8'h30;
    localparam logic [7:0] CH_NINE = 8'h39;
    localparam logic [7:0] CH_MUL  = 8'h2A;
    localparam logic [7:0] CH_ADD  = 8'h2B;

    function automatic logic is_digit(input logic [7:0] b);
        return (b >= CH_ZERO) && (b <= CH_NINE);
    endfunction

    function automatic logic is_op(input logic [7:0] b);
        return (b == CH_MUL) || (b == CH_ADD);
    endfunction

endpackage

// File: rtl/expr_check.sv
// Byte-serial recogniser for D (O D)*; ERR is absorbing until restart.
// Restart returns to INIT and takes priority over a consumed byte.
module expr_check
    import expr_arbiter_pkg::*;
(
    input  logic       clk,
    input  logic       clr,
    input  logic       restart,
    input  logic       en,
    input  logic [7:0] byte_val,
    output chk_t       state
);

    chk_t nxt;

    always_comb begin
        nxt = state;
        unique case (state)
            C_INIT:  nxt = is_digit(byte_val) ? C_NUM : C_ERR;
            C_NUM:   nxt = is_op(byte_val) ? C_OP : C_ERR;
            C_OP:    nxt = is_digit(byte_val) ? C_NUM : C_ERR;
            C_ERR:   nxt = C_ERR;
            default: nxt = C_ERR;
        endcase
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state <= C_INIT;
        end else if (restart) begin
            state <= C_INIT;
        end else if (en) begin
            state <= nxt;
        end
    end

endmodule

// File: rtl/expr_arbiter.sv
// Round-robin arbiter that lends one expression checker to two byte streams.
// Ownership is held for a whole expression; a verdict pulses one cycle later.
module expr_arbiter
    import expr_arbiter_pkg::*;
#(
    parameter int MAX_LEN = 16
) (
    input  logic       clk,
    input  logic       clr,
    input  logic       req0_valid,
    input  logic [7:0] req0_data,
    input  logic       req0_last,
    output logic       req0_ready,
    input  logic       req1_valid,
    input  logic [7:0] req1_data,
    input  logic       req1_last,
    output logic       req1_ready,
    output logic       grant,
    output logic       busy,
    output logic       res_valid,
    output logic       res_ok,
    output logic       res_ovf,
    output logic       res_id
);

    localparam logic [7:0] LIMIT = 8'(MAX_LEN);

    fsm_t       state;
    fsm_t       nxt;
    chk_t       chk;
    logic       pref;
    logic [7:0] cnt;
    logic       ovf;
    logic       any;
    logic       winner;
    logic       sel_valid;
    logic       sel_last;
    logic [7:0] sel_data;
    logic       in_run;
    logic       hs;
    logic       restart;

    assign any       = req0_valid | req1_valid;
    assign winner    = (req0_valid & req1_valid) ? pref : req1_valid;
    assign sel_valid = grant ? req1_valid : req0_valid;
    assign sel_last  = grant ? req1_last : req0_last;
    assign sel_data  = grant ? req1_data : req0_data;
    assign in_run    = (state == S_RUN);
    assign hs        = in_run & sel_valid;

    always_comb begin
        nxt     = state;
        restart = 1'b0;
        unique case (state)
            S_IDLE: begin
                if (any) begin
                    nxt     = S_RUN;
                    restart = 1'b1;
                end
            end
            S_RUN: begin
                if (hs && sel_last) nxt = S_REPORT;
            end
            S_REPORT: nxt = S_IDLE;
            default:  nxt = S_IDLE;
        endcase
    end

    // pref names the requester that wins the next two-way contest
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state <= S_IDLE;
            grant <= 1'b0;
            pref  <= 1'b0;
            cnt   <= 8'd0;
            ovf   <= 1'b0;
        end else begin
            state <= nxt;
            if (state == S_IDLE && any) begin
                grant <= winner;
                pref  <= ~winner;
                cnt   <= 8'd0;
                ovf   <= 1'b0;
            end else if (hs) begin
                if (cnt == LIMIT) ovf <= 1'b1;
                if (cnt != 8'hFF) cnt <= cnt + 8'd1;
            end
        end
    end

    expr_check u_check (
        .clk      (clk),
        .clr      (clr),
        .restart  (restart),
        .en       (hs),
        .byte_val (sel_data),
        .state    (chk)
    );

    assign req0_ready = in_run & ~grant;
    assign req1_ready = in_run & grant;
    assign busy       = (state != S_IDLE);
    assign res_valid  = (state == S_REPORT);
    assign res_id     = res_valid & grant;
    assign res_ovf    = res_valid & ovf;
    assign res_ok     = res_valid & (chk == C_NUM) & ~ovf;

endmodule

// File: tb/tb_expr_arbiter.sv
// Directed bench: a default-size and a MAX_LEN=4 arbiter run in lockstep.
// Verdicts are queued as {id,ok,ovf} and compared to hand-derived values.
module tb_expr_arbiter;

    logic       clk = 1'b0;
    logic       clr;
    logic       req0_valid, req0_last, req1_valid, req1_last;
    logic [7:0] req0_data, req1_data;

    logic a_r0, a_r1, a_grant, a_busy, a_rv, a_ok, a_ovf, a_id;
    logic b_r0, b_r1, b_grant, b_busy, b_rv, b_ok, b_ovf, b_id;

    int errors = 0;
    int checks = 0;
    int quiet_bad = 0;
    int lock_bad = 0;
    int cross_bad = 0;

    logic [2:0] qa[$];
    logic [2:0] qb[$];

    always #5 clk = ~clk;

    expr_arbiter u_a (
        .clk(clk), .clr(clr),
        .req0_valid(req0_valid), .req0_data(req0_data),
        .req0_last(req0_last), .req0_ready(a_r0),
        .req1_valid(req1_valid), .req1_data(req1_data),
        .req1_last(req1_last), .req1_ready(a_r1),
        .grant(a_grant), .busy(a_busy), .res_valid(a_rv),
        .res_ok(a_ok), .res_ovf(a_ovf), .res_id(a_id)
    );

    expr_arbiter #(.MAX_LEN(4)) u_b (
        .clk(clk), .clr(clr),
        .req0_valid(req0_valid), .req0_data(req0_data),
        .req0_last(req0_last), .req0_ready(b_r0),
        .req1_valid(req1_valid), .req1_data(req1_data),
        .req1_last(req1_last), .req1_ready(b_r1),
        .grant(b_grant), .busy(b_busy), .res_valid(b_rv),
        .res_ok(b_ok), .res_ovf(b_ovf), .res_id(b_id)
    );

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (a_rv) qa.push_back({a_id, a_ok, a_ovf});
        if (b_rv) qb.push_back({b_id, b_ok, b_ovf});
        if (!a_rv && (a_ok || a_ovf || a_id)) quiet_bad++;
        if (!b_rv && (b_ok || b_ovf || b_id)) quiet_bad++;
        if (a_r0 !== b_r0 || a_r1 !== b_r1) lock_bad++;
        if (a_busy && !a_grant && a_r1) cross_bad++;
        if (a_busy && a_grant && a_r0) cross_bad++;
    end

    task automatic drive(input int n, input logic v, input logic [7:0] d,
                         input logic l);
        if (n == 0) begin
            req0_valid = v; req0_data = d; req0_last = l;
        end else begin
            req1_valid = v; req1_data = d; req1_last = l;
        end
    endtask

    function automatic logic rdy(input int n);
        return (n == 0) ? a_r0 : a_r1;
    endfunction

    // Sends up to lim bytes of s; a truncated send leaves valid high.
    task automatic send(input int n, input string s, input int lim);
        int idx = 0;
        int cyc = 0;
        int len = s.len();
        int stop = (lim < len) ? lim : len;
        logic hs;
        drive(n, 1'b1, s[0], len == 1);
        while (idx < stop && cyc < 60) begin
            @(negedge clk);
            hs = rdy(n);
            @(posedge clk);
            #1;
            cyc++;
            if (hs) begin
                idx++;
                if (idx < len) drive(n, 1'b1, s[idx], idx == len - 1);
                else drive(n, 1'b0, 8'h00, 1'b0);
            end
        end
        check({"done_", s}, idx, stop);
        if (stop == len) begin
            check({"lat_a_", s}, a_rv, 1'b1);
            check({"lat_b_", s}, b_rv, 1'b1);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic expect_res(input string tag, input int i,
                              input logic [2:0] ea, input logic [2:0] eb);
        check({tag, "_a"}, qa[i], ea);
        check({tag, "_b"}, qb[i], eb);
    endtask

    task automatic expect_n(input string tag, input int n);
        check({tag, "_na"}, qa.size(), n);
        check({tag, "_nb"}, qb.size(), n);
    endtask

    initial begin
        clr = 1'b1;
        drive(0, 1'b0, 8'h00, 1'b0);
        drive(1, 1'b0, 8'h00, 1'b0);
        #2;
        check("rst_busy", a_busy, 1'b0);
        check("rst_ready", {a_r0, a_r1}, 2'b00);
        check("rst_res", {a_rv, a_ok, a_ovf, a_id}, 4'b0);
        check("rst_grant", a_grant, 1'b0);
        idle(2);
        clr = 1'b0;
        idle(1);

        // both valid from reset: req0 first, then req1, and again
        fork
            send(0, "3", 99);
            send(1, "3", 99);
        join
        idle(2);
        fork
            send(0, "3", 99);
            send(1, "3", 99);
        join
        idle(2);
        expect_n("rr", 4);
        expect_res("rr0", 0, 3'b010, 3'b010);
        expect_res("rr1", 1, 3'b110, 3'b110);
        expect_res("rr2", 2, 3'b010, 3'b010);
        expect_res("rr3", 3, 3'b110, 3'b110);
        qa.delete(); qb.delete();

        send(0, "1+2*3", 99); idle(2);
        send(1, "12", 99);    idle(2);
        send(0, "1+", 99);    idle(2);
        send(0, "7", 99);     idle(2);
        send(0, "1+2+3", 99); idle(2);
        send(0, "1+2", 99);   idle(2);
        send(0, "5*", 99);    idle(2);
        send(0, "+", 99);     idle(2);
        expect_n("dir", 8);
        expect_res("mixed", 0, 3'b010, 3'b001);
        expect_res("two_dig", 1, 3'b100, 3'b100);
        expect_res("trail_op", 2, 3'b000, 3'b000);
        expect_res("single", 3, 3'b010, 3'b010);
        expect_res("len5", 4, 3'b010, 3'b001);
        expect_res("len3", 5, 3'b010, 3'b010);
        expect_res("trail_mul", 6, 3'b000, 3'b000);
        expect_res("lone_op", 7, 3'b000, 3'b000);
        qa.delete(); qb.delete();

        // req1 waits with valid high while req0 owns the checker
        fork
            send(0, "1+2*3", 99);
            begin
                idle(1);
                send(1, "9", 99);
            end
        join
        idle(2);
        expect_n("hold", 2);
        expect_res("hold0", 0, 3'b010, 3'b001);
        expect_res("hold1", 1, 3'b110, 3'b110);
        check("no_cross_ready", cross_bad, 0);
        qa.delete(); qb.delete();

        // clear mid-expression abandons it
        send(0, "1+2", 2);
        #2;
        clr = 1'b1;
        #1;
        check("clr_ready", {a_r0, a_r1}, 2'b00);
        check("clr_busy", a_busy, 1'b0);
        drive(0, 1'b0, 8'h00, 1'b0);
        #4;
        clr = 1'b0;
        idle(4);
        expect_n("clr_quiet", 0);
        send(0, "5", 99);
        idle(2);
        expect_n("post_clr", 1);
        expect_res("post_clr", 0, 3'b010, 3'b010);

        check("quiet_fields", quiet_bad, 0);
        check("lockstep_ready", lock_bad, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
